// File: rtl/aes_ctr_engine.sv
// Iterative AES-CTR engine: encrypts the counter block one round per clock and XORs
// the keystream into the input block. Round keys are fetched from an external store.
module aes_ctr_engine #(
  parameter int KEY_BITS = 256,
  parameter int CTR_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] iv_i,
  output logic         cfg_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_i,
  output logic [127:0] ctr_o,
  output logic         busy
);
  localparam int NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_ctr_engine: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   state_reg;
  logic [3:0]   r_reg;
  logic [127:0] st_reg;
  logic [127:0] data_reg;
  logic [127:0] ctr_reg;
  logic [127:0] out_data_reg;
  logic         out_valid_reg;
  logic         cfg_err_reg;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  // Byte i lives at bits 127-8i; column = i/4, row = i%4.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int SRC = 4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4);
      assign sb[127-8*gi -: 8] = SBOX[st_reg[127-8*gi -: 8]];
      assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[127-32*gi -: 8];
      assign a1 = sr[119-32*gi -: 8];
      assign a2 = sr[111-32*gi -: 8];
      assign a3 = sr[103-32*gi -: 8];
      assign mc[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      st_reg        <= '0;
      data_reg      <= '0;
      ctr_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_load && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          // A config load wins over a pending input block.
          if (cfg_load) begin
            ctr_reg <= iv_i;
          end else if (in_valid) begin
            data_reg  <= in_data;
            st_reg    <= ctr_reg ^ rk_i;
            r_reg     <= 4'd1;
            ctr_reg[CTR_BITS-1:0] <= ctr_reg[CTR_BITS-1:0] + CTR_BITS'(1);
            state_reg <= (NR == 1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          st_reg <= mc ^ rk_i;
          r_reg  <= r_reg + 4'd1;
          if (r_reg == 4'(NR - 1)) begin
            state_reg <= FINAL;
          end
        end
        FINAL: begin
          out_data_reg  <= sr ^ rk_i ^ data_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        default: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rk_idx = 4'd0;
    case (state_reg)
      ROUND:   rk_idx = r_reg;
      FINAL:   rk_idx = 4'(NR);
      default: rk_idx = 4'd0;
    endcase
  end

  assign in_ready  = rst && (state_reg == IDLE) && !cfg_load;
  assign busy      = (state_reg != IDLE);
  assign cfg_err   = cfg_err_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ctr_o     = ctr_reg;
endmodule

// File: tb/tb_aes_ctr_engine.sv
// Bench for aes_ctr_engine: FIPS-197 known answers plus random blocks checked against
// an arithmetic AES model (S-box derived from GF(2^8) inverses) and a counter model.
module tb_aes_ctr_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // AES-256 instance
  logic         cfg_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] iv_i = '0, in_data = '0, rk_i;
  logic         cfg_err, in_ready, out_valid, busy;
  logic [127:0] out_data, ctr_o;
  logic [3:0]   rk_idx;

  // AES-128 instance
  logic         s_cfg_load = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [127:0] s_iv = '0, s_in_data = '0, s_rk_i;
  logic         s_cfg_err, s_in_ready, s_out_valid, s_busy;
  logic [127:0] s_out_data, s_ctr;
  logic [3:0]   s_rk_idx;

  logic [127:0] rk256 [0:15];
  logic [127:0] rk128 [0:15];
  logic [7:0]   sbt [0:255];
  logic [127:0] ctr_model;
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [127:0] IV1    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  assign rk_i   = rk256[rk_idx];
  assign s_rk_i = rk128[s_rk_idx];

  aes_ctr_engine #(.KEY_BITS(256), .CTR_BITS(32)) u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .iv_i(iv_i), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .rk_idx(rk_idx), .rk_i(rk_i),
    .ctr_o(ctr_o), .busy(busy)
  );

  aes_ctr_engine #(.KEY_BITS(128), .CTR_BITS(32)) u_dut128 (
    .clk(clk), .rst(rst), .cfg_load(s_cfg_load), .iv_i(s_iv), .cfg_err(s_cfg_err),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .rk_idx(s_rk_idx), .rk_i(s_rk_i),
    .ctr_o(s_ctr), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from the multiplicative inverse followed by the FIPS-197 affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic expand_key(input int nk, input logic [255:0] key, input int sel);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) begin
      if (sel == 0) rk256[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
      else          rk128[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
    end
  endtask

  function automatic logic [127:0] rkey(input int sel, input int j);
    return (sel == 0) ? rk256[j] : rk128[j];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] blk, input int nr, input int sel);
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [127:0] k, res;
    k = rkey(sel, 0);
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rnd == nr) ? t[4*c+r] :
                     gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^
                     t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      k = rkey(sel, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic load_iv(input logic [127:0] iv);
    @(negedge clk);
    cfg_load = 1'b1;
    iv_i = iv;
    #1 check("in_ready_on_load", in_ready, 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    ctr_model = iv;
    check("ctr_loaded", ctr_o, iv);
  endtask

  task automatic run_block(input logic [127:0] din, input int hold, input int cfg_at,
                           output logic [127:0] dout);
    logic [127:0] exp_out, held;
    int edges;
    exp_out = din ^ aes_enc(ctr_model, 14, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = din;
    #1 check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctr_model = {ctr_model[127:32], ctr_model[31:0] + 32'd1};
    check("ctr_after_accept", ctr_o, ctr_model);
    check("in_ready_busy", in_ready, 0);
    edges = 0;
    while (!out_valid && edges < 40) begin
      if (edges == 5) check("rk_idx_round", rk_idx, 6);
      if (edges == 13) check("rk_idx_final", rk_idx, 14);
      if (cfg_at >= 0 && edges == cfg_at) begin
        cfg_load = 1'b1;
        iv_i = rand128();
      end
      @(posedge clk); #1;
      edges++;
      if (cfg_at >= 0 && edges == cfg_at + 1) begin
        cfg_load = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("ctr_unchanged", ctr_o, ctr_model);
      end
      if (cfg_at >= 0 && edges == cfg_at + 2) check("cfg_err_clear", cfg_err, 0);
    end
    check("latency", edges, 14);
    check("out_data", out_data, exp_out);
    dout = out_data;
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("back_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dout, v;
    int edges;
    build_sbox();
    expand_key(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0);
    expand_key(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1);
    ctr_model = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ctr", ctr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // AES-256 known answer
    load_iv(IV1);
    run_block('0, 0, -1, dout);
    check("kat256", dout, KAT256);

    // AES-128 known answer on the second instance
    @(negedge clk);
    s_cfg_load = 1'b1;
    s_iv = IV1;
    @(negedge clk);
    s_cfg_load = 1'b0;
    s_in_valid = 1'b1;
    s_in_data = '0;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    edges = 0;
    while (!s_out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency128", edges, 10);
    check("kat128", s_out_data, KAT128);
    check("model128", s_out_data, aes_enc(IV1, 10, 1));
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("idle128", s_busy, 0);

    // Counter wrap of the low word only
    load_iv(128'h00112233445566778899aabbffffffff);
    run_block(rand128(), 0, -1, dout);
    check("ctr_wrap", ctr_o, 128'h00112233445566778899aabb00000000);
    run_block(rand128(), 0, -1, dout);

    // Back-pressure in OUT
    run_block(rand128(), 5, -1, dout);

    // cfg_load during ROUND, then a load that collides with in_valid in IDLE
    load_iv(IV1);
    run_block('0, 0, 3, dout);
    check("kat256_after_cfg", dout, KAT256);
    v = rand128();
    @(negedge clk);
    cfg_load = 1'b1;
    iv_i = v;
    in_valid = 1'b1;
    in_data = rand128();
    #1 check("in_ready_load_prio", in_ready, 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    check("no_accept_on_load", busy, 0);
    check("ctr_load_prio", ctr_o, v);
    ctr_model = v;

    // Random traffic with random back-pressure
    for (int n = 0; n < 4; n++) run_block(rand128(), $urandom_range(0, 3), -1, dout);

    // Reset in the middle of a block
    @(negedge clk);
    in_valid = 1'b1;
    in_data = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_ctr", ctr_o, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b1;
    ctr_model = '0;
    repeat (16) @(posedge clk);
    #1 check("abort_no_output", out_valid, 0);
    run_block(rand128(), 0, -1, dout);
    load_iv(IV1);
    run_block('0, 1, -1, dout);
    check("kat256_after_reset", dout, KAT256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
